sha256_block_ctrl: RTL and testbench

Top-level sequencer between the UART Message Packer and the SHA-256 message-schedule/compression datapath. It accepts the packer's 16 32-bit words per 512-bit block and forwards them into the schedule buffer. It then runs the 64 compression rounds and issues the hash-state update. On the last block it sequences the 8-word digest readout. It also owns multi-block chaining, back-pressure and partial-block timeout recovery.

---
 rtl/sha256_block_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sha256_block_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_ctrl.sv
// Block sequencer between the UART message packer and the SHA-256 datapath:
// loads 16 schedule words, runs the compression rounds, updates the hash, reads out the digest.
module sha256_block_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT_LIMIT = 4340,
    parameter int NUM_ROUNDS    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mp_dv_in,
    input  logic [DATA_WIDTH-1:0] mp_word_in,
    input  logic                  mp_last_in,
    output logic                  ready_out,
    output logic                  ws_load_out,
    output logic [3:0]            ws_idx_out,
    output logic [DATA_WIDTH-1:0] ws_word_out,
    output logic                  core_init_out,
    output logic                  round_en_out,
    output logic [5:0]            round_idx_out,
    output logic                  core_update_out,
    output logic                  digest_rd_out,
    output logic [2:0]            digest_idx_out,
    output logic                  done_out,
    output logic                  busy_out,
    output logic                  err_out
);

    localparam int TMO_W = $clog2(TIMEOUT_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DIGEST} state_t;

    state_t             state;
    logic [3:0]         word_cnt;
    logic [5:0]         round_cnt;
    logic               first_blk;
    logic               last_lat;
    logic               blk_full;
    logic [TMO_W-1:0]   tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            word_cnt        <= '0;
            round_cnt       <= '0;
            first_blk       <= 1'b1;
            last_lat        <= 1'b0;
            blk_full        <= 1'b0;
            tmo_cnt         <= '0;
            err_out         <= 1'b0;
            ready_out       <= 1'b1;
            busy_out        <= 1'b0;
            ws_load_out     <= 1'b0;
            ws_idx_out      <= '0;
            ws_word_out     <= '0;
            core_init_out   <= 1'b0;
            round_en_out    <= 1'b0;
            round_idx_out   <= '0;
            core_update_out <= 1'b0;
            digest_rd_out   <= 1'b0;
            digest_idx_out  <= '0;
            done_out        <= 1'b0;
        end else begin
            ws_load_out     <= 1'b0;
            core_init_out   <= 1'b0;
            round_en_out    <= 1'b0;
            core_update_out <= 1'b0;
            digest_rd_out   <= 1'b0;
            done_out        <= 1'b0;

            // A word offered while not ready is lost; the sequence itself carries on.
            if (mp_dv_in && !ready_out)
                err_out <= 1'b1;

            case (state)
                IDLE: begin
                    if (mp_dv_in) begin
                        ws_load_out   <= 1'b1;
                        ws_idx_out    <= 4'd0;
                        ws_word_out   <= mp_word_in;
                        core_init_out <= first_blk;
                        word_cnt      <= 4'd1;
                        tmo_cnt       <= '0;
                        busy_out      <= 1'b1;
                        state         <= LOAD;
                    end
                end

                LOAD: begin
                    if (blk_full) begin
                        // Word 15's load strobe is out; rounds start on the following cycle.
                        blk_full      <= 1'b0;
                        round_cnt     <= '0;
                        round_en_out  <= 1'b1;
                        round_idx_out <= '0;
                        state         <= ROUND;
                    end else if (mp_dv_in) begin
                        ws_load_out <= 1'b1;
                        ws_idx_out  <= word_cnt;
                        ws_word_out <= mp_word_in;
                        tmo_cnt     <= '0;
                        if (word_cnt == 4'd15) begin
                            blk_full  <= 1'b1;
                            last_lat  <= mp_last_in;
                            ready_out <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_LIMIT - 1)) begin
                        // Stalled partial block: drop it and treat the next word as a new message.
                        tmo_cnt   <= '0;
                        word_cnt  <= '0;
                        first_blk <= 1'b1;
                        last_lat  <= 1'b0;
                        err_out   <= 1'b1;
                        busy_out  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ROUND: begin
                    if (round_cnt == 6'(NUM_ROUNDS - 1)) begin
                        core_update_out <= 1'b1;
                        state           <= UPDATE;
                    end else begin
                        round_cnt     <= round_cnt + 6'd1;
                        round_en_out  <= 1'b1;
                        round_idx_out <= round_cnt + 6'd1;
                    end
                end

                UPDATE: begin
                    if (last_lat) begin
                        digest_rd_out  <= 1'b1;
                        digest_idx_out <= '0;
                        state          <= DIGEST;
                    end else begin
                        first_blk <= 1'b0;
                        word_cnt  <= '0;
                        ready_out <= 1'b1;
                        busy_out  <= 1'b0;
                        state     <= IDLE;
                    end
                end

                DIGEST: begin
                    if (digest_idx_out == 3'd7) begin
                        first_blk <= 1'b1;
                        last_lat  <= 1'b0;
                        word_cnt  <= '0;
                        ready_out <= 1'b1;
                        busy_out  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        digest_rd_out  <= 1'b1;
                        digest_idx_out <= digest_idx_out + 3'd1;
                        done_out       <= (digest_idx_out == 3'd6);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Randomised bench for sha256_block_ctrl: a slot-scheduled model of the block timeline
// predicts every output each cycle, plus literal checks on the "abc" and corner scenarios.
module tb_sha256_block_ctrl;

    localparam int TMO = 4340;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mp_dv_in = 1'b0;
    logic [31:0] mp_word_in = '0;
    logic        mp_last_in = 1'b0;
    logic        ready_out, ws_load_out, core_init_out, round_en_out, core_update_out;
    logic        digest_rd_out, done_out, busy_out, err_out;
    logic [3:0]  ws_idx_out;
    logic [31:0] ws_word_out;
    logic [5:0]  round_idx_out;
    logic [2:0]  digest_idx_out;

    sha256_block_ctrl dut (
        .clk(clk), .rst(rst), .mp_dv_in(mp_dv_in), .mp_word_in(mp_word_in),
        .mp_last_in(mp_last_in), .ready_out(ready_out), .ws_load_out(ws_load_out),
        .ws_idx_out(ws_idx_out), .ws_word_out(ws_word_out), .core_init_out(core_init_out),
        .round_en_out(round_en_out), .round_idx_out(round_idx_out),
        .core_update_out(core_update_out), .digest_rd_out(digest_rd_out),
        .digest_idx_out(digest_idx_out), .done_out(done_out), .busy_out(busy_out),
        .err_out(err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit        vld, rstchk, ws_load, init, ren, upd, dig, done, ready, busy, err;
        bit [3:0]  ws_idx;
        bit [31:0] ws_word;
        bit [5:0]  ridx;
        bit [2:0]  didx;
    } exp_t;

    exp_t ring[128];
    int   lock_start = 0, lock_end = 0, m_words = 0, m_last_t = 0;
    bit   m_first = 1'b1, m_loading = 1'b0, m_err = 1'b0;

    int total = 0, bad = 0;
    int cnt_init = 0, cnt_round = 0, cnt_upd = 0, cnt_done = 0, cnt_load = 0, cnt_dig = 0;
    int t_first = 0, t_done = 0;
    logic [31:0] obs_word[16];

    function automatic bit m_ready(input int s);
        return !(s >= lock_start && s < lock_end);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare();
        int   c;
        exp_t e;
        c = cyc;
        e = ring[c % 128];
        if (e.vld) begin
            chk("ready", ready_out, e.ready);
            chk("busy", busy_out, e.busy);
            chk("err", err_out, e.err);
            chk("ws_load", ws_load_out, e.ws_load);
            chk("core_init", core_init_out, e.init);
            chk("round_en", round_en_out, e.ren);
            chk("core_update", core_update_out, e.upd);
            chk("digest_rd", digest_rd_out, e.dig);
            chk("done", done_out, e.done);
            if (e.ws_load) begin
                chk("ws_idx", ws_idx_out, e.ws_idx);
                chk("ws_word", ws_word_out, e.ws_word);
            end
            if (e.ren) chk("round_idx", round_idx_out, e.ridx);
            if (e.dig) chk("digest_idx", digest_idx_out, e.didx);
            if (e.rstchk) begin
                chk("rst_ws_idx", ws_idx_out, 0);
                chk("rst_ws_word", ws_word_out, 0);
                chk("rst_round_idx", round_idx_out, 0);
                chk("rst_digest_idx", digest_idx_out, 0);
            end
        end
        if (ws_load_out === 1'b1) begin
            cnt_load++;
            obs_word[ws_idx_out] = ws_word_out;
            if (ws_idx_out == 4'd0) t_first = c;
        end
        if (core_init_out === 1'b1) cnt_init++;
        if (round_en_out === 1'b1) cnt_round++;
        if (core_update_out === 1'b1) cnt_upd++;
        if (digest_rd_out === 1'b1) cnt_dig++;
        if (done_out === 1'b1) begin
            cnt_done++;
            t_done = c;
        end
        ring[c % 128] = '{default: 0};
    endtask

    // Inputs driven now are seen at the next rising edge; their effects land in slot n.
    task automatic model_step(input bit dv, input logic [31:0] w, input bit last, input bit r);
        int c, n;
        c = cyc;
        n = cyc + 1;
        if (r) begin
            for (int i = 0; i < 128; i++) ring[i] = '{default: 0};
            lock_start = 0; lock_end = 0; m_words = 0;
            m_first = 1'b1; m_loading = 1'b0; m_err = 1'b0;
            ring[n % 128].rstchk = 1'b1;
        end else if (dv && !m_ready(c)) begin
            m_err = 1'b1;
        end else if (dv) begin
            ring[n % 128].ws_load = 1'b1;
            ring[n % 128].ws_idx  = 4'(m_words);
            ring[n % 128].ws_word = w;
            ring[n % 128].init    = (m_words == 0) && m_first;
            m_loading = 1'b1;
            m_last_t  = c;
            m_words++;
            if (m_words == 16) begin
                lock_start = n;
                for (int k = 0; k < 64; k++) begin
                    ring[(n + 1 + k) % 128].ren  = 1'b1;
                    ring[(n + 1 + k) % 128].ridx = 6'(k);
                end
                ring[(n + 65) % 128].upd = 1'b1;
                if (last) begin
                    for (int k = 0; k < 8; k++) begin
                        ring[(n + 66 + k) % 128].dig  = 1'b1;
                        ring[(n + 66 + k) % 128].didx = 3'(k);
                        ring[(n + 66 + k) % 128].done = (k == 7);
                    end
                    lock_end = n + 74;
                    m_first  = 1'b1;
                end else begin
                    lock_end = n + 66;
                    m_first  = 1'b0;
                end
                m_words   = 0;
                m_loading = 1'b0;
            end
        end else if (m_loading && (c - m_last_t == TMO)) begin
            m_err = 1'b1; m_loading = 1'b0; m_words = 0; m_first = 1'b1;
        end
        ring[n % 128].vld   = 1'b1;
        ring[n % 128].ready = m_ready(n);
        ring[n % 128].busy  = m_loading || !m_ready(n);
        ring[n % 128].err   = m_err;
    endtask

    task automatic step(input bit dv, input logic [31:0] w, input bit last, input bit r);
        @(negedge clk);
        compare();
        #1;
        mp_dv_in = dv; mp_word_in = w; mp_last_in = last; rst = r;
        model_step(dv, w, last, r);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, $urandom, 1'($urandom % 2), 1'b0);
    endtask

    task automatic send_block(input logic [31:0] w[16], input bit last, input int maxgap);
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(maxgap, 0));
            step(1'b1, w[i], (i == 15) ? last : 1'($urandom % 2), 1'b0);
        end
    endtask

    task automatic wait_free(input bit noise);
        int guard = 0;
        while (!m_ready(cyc + 1) && guard < 200) begin
            step(noise && ($urandom % 6 == 0), $urandom, 1'b0, 1'b0);
            guard++;
        end
        chk("wait_free_bound", guard < 200, 1);
    endtask

    logic [31:0] abc[16];
    logic [31:0] rw[16];
    int i0, r0, u0, d0, l0;

    initial begin
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        idle(2);

        // "abc", back-to-back words
        i0 = cnt_init; r0 = cnt_round; u0 = cnt_upd; d0 = cnt_done; l0 = cnt_load;
        send_block(abc, 1'b1, 0);
        wait_free(1'b0);
        idle(2);
        chk("abc_init_cnt", cnt_init - i0, 1);
        chk("abc_round_cnt", cnt_round - r0, 64);
        chk("abc_update_cnt", cnt_upd - u0, 1);
        chk("abc_done_cnt", cnt_done - d0, 1);
        chk("abc_load_cnt", cnt_load - l0, 16);
        chk("abc_latency", t_done - t_first, 88);
        chk("abc_word0", obs_word[0], 32'h61626380);
        chk("abc_word7", obs_word[7], 32'h0);
        chk("abc_word15", obs_word[15], 32'h00000018);
        chk("abc_busy_after", busy_out, 0);

        // two-block message
        i0 = cnt_init; u0 = cnt_upd; d0 = cnt_done; r0 = cnt_dig;
        for (int i = 0; i < 16; i++) rw[i] = $urandom;
        send_block(rw, 1'b0, 3);
        wait_free(1'b0);
        idle(1);
        for (int i = 0; i < 16; i++) rw[i] = $urandom;
        send_block(rw, 1'b1, 3);
        wait_free(1'b0);
        idle(2);
        chk("two_init_cnt", cnt_init - i0, 1);
        chk("two_update_cnt", cnt_upd - u0, 2);
        chk("two_done_cnt", cnt_done - d0, 1);
        chk("two_digest_cnt", cnt_dig - r0, 8);

        // word offered during round 10
        r0 = cnt_round; l0 = cnt_load;
        send_block(abc, 1'b1, 0);
        idle(11);
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        wait_free(1'b0);
        idle(2);
        chk("drop_err", err_out, 1);
        chk("drop_round_cnt", cnt_round - r0, 64);
        chk("drop_load_cnt", cnt_load - l0, 16);

        step(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        chk("rst_clears_err", err_out, 0);

        // partial block timeout, then a clean block
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        idle(TMO + 2);
        chk("tmo_busy", busy_out, 0);
        chk("tmo_err", err_out, 1);
        i0 = cnt_init; d0 = cnt_done;
        send_block(abc, 1'b1, 1);
        wait_free(1'b0);
        idle(2);
        chk("tmo_reinit", cnt_init - i0, 1);
        chk("tmo_done", cnt_done - d0, 1);

        // reset during round 30
        send_block(abc, 1'b0, 0);
        idle(31);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        chk("rst30_ready", ready_out, 1);
        chk("rst30_round_en", round_en_out, 0);
        chk("rst30_err", err_out, 0);
        i0 = cnt_init; d0 = cnt_done;
        send_block(abc, 1'b1, 0);
        wait_free(1'b0);
        idle(2);
        chk("rst30_init", cnt_init - i0, 1);
        chk("rst30_done", cnt_done - d0, 1);

        // random multi-block messages with noise while busy
        for (int m = 0; m < 6; m++) begin
            int nb;
            nb = 1 + $urandom % 3;
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 16; i++) rw[i] = $urandom;
                send_block(rw, b == nb - 1, 4);
                wait_free(1'b1);
            end
            idle($urandom_range(5, 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
